ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter and sequencer for the single-port 256x8 data RAM. It shares the RAM between the CPU load/store path and a debug/loader port (front-panel or serial memory load/inspect). It serialises accesses, drives the RAM address/data/write-enable from registered state, and returns read data to the winning requester, accounting for the RAM's one-cycle registered read latency.

## Interface
Parameters:
- AW, 8, address width (RAM depth 2^AW)
- DW, 8, data width

Ports:
- iCLK  in  1  single clock; all state changes on rising edge
- iRST_N  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted (write performed this cycle)
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DW  registered read data for CPU
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug port, same meaning as CPU fields
- dbg_gnt, dbg_rvalid  out  1  same meaning as CPU fields
- dbg_rdata  out  DW  registered read data for debug port
- ram_addr  out  AW  RAM address (registered)
- ram_data  out  DW  RAM write data (registered)
- ram_wren  out  1  RAM write enable (registered)
- ram_q  in  DW  RAM read data, valid one cycle after the address is presented
- busy  out  1  1 whenever state != IDLE

## Operation
- Reset: state=IDLE, last=DBG (CPU wins first tie). Every output is 0: gnt, rvalid, rdata, ram_addr, ram_data, ram_wren, busy.
- States: IDLE, ACCESS, WAIT.
- IDLE: if no req, remain. If exactly one req, that requester wins. If both, winner = the requester != last (round-robin). At the edge, latch winner, we, addr and wdata into ram_addr/ram_data/ram_wren (ram_wren = we). Set last=winner and go to ACCESS.
- ACCESS: assert winner gnt for one cycle. The RAM sees the latched address; a write commits at the end of this cycle. On the next edge, ram_wren goes to 0. A write returns to IDLE; a read goes to WAIT.
- WAIT: ram_q is valid. At the edge, capture ram_q into the winner rdata, assert winner rvalid for the next cycle, and go to IDLE. The other requester's rdata holds its value.
- rvalid is asserted during the following IDLE cycle, which may simultaneously arbitrate a new request.
- Requester rules:
  - Hold req and fields stable until gnt. Fields may change in the gnt cycle.
  - Dropping req before it is sampled in IDLE withdraws it with no effect.
  - req still high in the cycle after gnt is a new request.
  - req is ignored while busy.
- ram_addr/ram_data hold their last values in IDLE. Only ram_wren is cleared.
- No address decoding or MMIO here. The full AW range maps to RAM.

## Timing
- E0 = edge that samples req in IDLE.
- gnt: high in the cycle after E0.
- Write: RAM written at the end of the gnt cycle. Throughput is 1 write per 2 cycles.
- Read: rdata/rvalid valid 3 cycles after E0 (2 after gnt). Throughput is 1 read per 3 cycles.
- Worst-case wait for a continuously requesting port is one full opposing access (3 cycles) plus its own arbitration.
- Reset asserted mid-operation:
  - All outputs clear immediately and asynchronously. ram_wren drops without waiting for an edge.
  - Any pending rvalid is lost, and the in-flight write is undefined if it was cut inside ACCESS.
  - After release, the first edge is in IDLE with last=DBG.
- gnt and rvalid are never asserted for both ports in the same cycle.

## Test plan
- Reset: hold iRST_N=0 with both req=1 → all outputs 0 and busy=0. Release → cpu_gnt (not dbg_gnt) in the cycle after the first sampling edge.
- CPU write then read: write 0x5A to addr 0x10 → ram_wren=1 and ram_addr=0x10 in the cpu_gnt cycle only. Then read 0x10 → cpu_rvalid=1 with cpu_rdata=0x5A exactly 2 cycles after cpu_gnt; dbg_rvalid stays 0.
- Round-robin: both ports hold req=1 for reads at 0x01/0x02 (RAM preloaded 0xA1/0xA2) → grants alternate CPU, DBG, CPU… every 3 cycles. cpu_rdata=0xA1 and dbg_rdata=0xA2.
- Overlap: dbg_req raised during a CPU read's WAIT → dbg_gnt arrives in the cycle after cpu_rvalid, so the DBG request is sampled in the cycle cpu_rvalid is high.
- Withdrawal: pulse dbg_req for one cycle while busy=1 → no dbg_gnt, no RAM write.
- Reset mid-read: assert iRST_N=0 in WAIT → ram_wren=0 immediately, no rvalid after release, and the next CPU write of 0x33 to 0xFF completes normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port synchronous RAM
// shared by the CPU load/store path and the debug/loader port.
module ram_port_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    state_t        state;
    state_t        state_nxt;
    logic          last;           // last granted port, i.e. owner of the access in flight
    logic          last_nxt;
    logic          op_we;
    logic          op_we_nxt;
    logic [AW-1:0] ram_addr_nxt;
    logic [DW-1:0] ram_data_nxt;
    logic          ram_wren_nxt;
    logic          cpu_gnt_nxt;
    logic          dbg_gnt_nxt;
    logic          cpu_rvalid_nxt;
    logic          dbg_rvalid_nxt;
    logic [DW-1:0] cpu_rdata_nxt;
    logic [DW-1:0] dbg_rdata_nxt;
    logic          busy_nxt;
    logic          win_dbg;

    // A lone requester wins; on a tie the port not served last wins.
    assign win_dbg = dbg_req & (~cpu_req | (last == PORT_CPU));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            last       <= PORT_DBG;
            op_we      <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_wren   <= 1'b0;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            op_we      <= op_we_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_data   <= ram_data_nxt;
            ram_wren   <= ram_wren_nxt;
            cpu_gnt    <= cpu_gnt_nxt;
            dbg_gnt    <= dbg_gnt_nxt;
            cpu_rvalid <= cpu_rvalid_nxt;
            dbg_rvalid <= dbg_rvalid_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            dbg_rdata  <= dbg_rdata_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_nxt       = last;
        op_we_nxt      = op_we;
        ram_addr_nxt   = ram_addr;
        ram_data_nxt   = ram_data;
        ram_wren_nxt   = 1'b0;
        cpu_gnt_nxt    = 1'b0;
        dbg_gnt_nxt    = 1'b0;
        cpu_rvalid_nxt = 1'b0;
        dbg_rvalid_nxt = 1'b0;
        cpu_rdata_nxt  = cpu_rdata;
        dbg_rdata_nxt  = dbg_rdata;
        busy_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (cpu_req | dbg_req) begin
                    last_nxt     = win_dbg;
                    op_we_nxt    = win_dbg ? dbg_we    : cpu_we;
                    ram_addr_nxt = win_dbg ? dbg_addr  : cpu_addr;
                    ram_data_nxt = win_dbg ? dbg_wdata : cpu_wdata;
                    ram_wren_nxt = op_we_nxt;
                    cpu_gnt_nxt  = ~win_dbg;
                    dbg_gnt_nxt  = win_dbg;
                    state_nxt    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_nxt = op_we ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // RAM output is valid now; hand it to the owner of this access.
                if (last == PORT_DBG) begin
                    dbg_rdata_nxt  = ram_q;
                    dbg_rvalid_nxt = 1'b1;
                end else begin
                    cpu_rdata_nxt  = ram_q;
                    cpu_rvalid_nxt = 1'b1;
                end
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed steps plus random traffic, checked against a
// transaction-level model (grant edges, read-return edges, shadow memory).
module tb_ram_port_arbiter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          iCLK = 1'b0;
    logic          iRST_N;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_wren, busy;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy)
    );

    always #5 iCLK = ~iCLK;

    // Single-port RAM with registered read, plus a loader port used during reset.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge iCLK) begin
        if (pre_we)        mem[pre_addr] <= pre_data;
        else if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    int            n_assert = 0;
    int            n_fail   = 0;
    int            edge_n   = 0;
    int            free_edge, g_edge, rv_edge;
    logic          g_port, g_we, rv_port, last_m;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data, rv_data, exp_crd, exp_drd;
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_m    = 1'b1;
        free_edge = edge_n;
        g_edge    = -100;
        rv_edge   = -100;
        g_port    = 1'b0;
        g_we      = 1'b0;
        rv_port   = 1'b0;
        rv_data   = '0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_crd   = '0;
        exp_drd   = '0;
    endtask

    task automatic chk_all_zero();
        chk("rst_cpu_gnt",    32'(cpu_gnt),    0);
        chk("rst_dbg_gnt",    32'(dbg_gnt),    0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
        chk("rst_cpu_rdata",  32'(cpu_rdata),  0);
        chk("rst_dbg_rdata",  32'(dbg_rdata),  0);
        chk("rst_ram_addr",   32'(ram_addr),   0);
        chk("rst_ram_data",   32'(ram_data),   0);
        chk("rst_ram_wren",   32'(ram_wren),   0);
        chk("rst_busy",       32'(busy),       0);
    endtask

    // Mid-cycle reset: outputs must clear before any edge, then stay clear.
    task automatic apply_reset(input int cycles);
        iRST_N = 1'b0;
        #1;
        chk_all_zero();
        repeat (cycles) begin
            @(posedge iCLK);
            edge_n++;
        end
        #1;
        chk_all_zero();
        iRST_N = 1'b1;
        model_reset();
    endtask

    // One clock: predict the upcoming edge from the rules, then check everything after it.
    task automatic step();
        logic w;
        if (edge_n >= free_edge && (cpu_req || dbg_req)) begin
            w        = (cpu_req && dbg_req) ? ~last_m : dbg_req;
            last_m   = w;
            g_edge   = edge_n;
            g_port   = w;
            g_we     = w ? dbg_we    : cpu_we;
            exp_addr = w ? dbg_addr  : cpu_addr;
            exp_data = w ? dbg_wdata : cpu_wdata;
            if (g_we) begin
                ref_mem[exp_addr] = exp_data;
                free_edge = edge_n + 2;
            end else begin
                rv_edge   = edge_n + 2;
                rv_port   = w;
                rv_data   = ref_mem[exp_addr];
                free_edge = edge_n + 3;
            end
        end
        @(posedge iCLK);
        #1;
        if (edge_n == rv_edge) begin
            if (rv_port) exp_drd = rv_data;
            else         exp_crd = rv_data;
        end
        chk("cpu_gnt",    32'(cpu_gnt),    32'(edge_n == g_edge && !g_port));
        chk("dbg_gnt",    32'(dbg_gnt),    32'(edge_n == g_edge && g_port));
        chk("ram_wren",   32'(ram_wren),   32'(edge_n == g_edge && g_we));
        chk("ram_addr",   32'(ram_addr),   32'(exp_addr));
        chk("ram_data",   32'(ram_data),   32'(exp_data));
        chk("busy",       32'(busy),       32'(edge_n < free_edge - 1));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(edge_n == rv_edge && !rv_port));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(edge_n == rv_edge && rv_port));
        chk("cpu_rdata",  32'(cpu_rdata),  32'(exp_crd));
        chk("dbg_rdata",  32'(dbg_rdata),  32'(exp_drd));
        chk("gnt_excl",   32'(cpu_gnt & dbg_gnt),       0);
        chk("rv_excl",    32'(cpu_rvalid & dbg_rvalid), 0);
        edge_n++;
    endtask

    task automatic wait_gnt(input logic port);
        int   k   = 0;
        logic got = 1'b0;
        while (!got && k < 20) begin
            step();
            k++;
            got = port ? dbg_gnt : cpu_gnt;
        end
        chk(port ? "dbg_gnt_timeout" : "cpu_gnt_timeout", 32'(got), 1);
        if (port) dbg_req = 1'b0;
        else      cpu_req = 1'b0;
    endtask

    task automatic cpu_do(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        wait_gnt(1'b0);
    endtask

    task automatic new_txn(output logic we, output logic [AW-1:0] a, output logic [DW-1:0] d);
        we = 1'($urandom_range(0, 1));
        a  = AW'($urandom);
        d  = DW'($urandom);
    endtask

    initial begin
        int cg, dg;
        iRST_N  = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
        pre_we  = 1'b0; pre_addr = '0; pre_data = '0;

        // Preload RAM and shadow while held in reset with both requests asserted.
        for (int i = 0; i < int'(DEPTH); i++) begin
            pre_we   = 1'b1;
            pre_addr = AW'(i);
            pre_data = (i == 1) ? 8'hA1 : (i == 2) ? 8'hA2 : DW'($urandom);
            ref_mem[i] = pre_data;
            @(posedge iCLK);
            #1;
            edge_n++;
        end
        pre_we = 1'b0;
        chk_all_zero();
        iRST_N = 1'b1;
        model_reset();

        // First tie after reset goes to the CPU.
        step();
        chk("first_cpu_gnt", 32'(cpu_gnt), 1);
        chk("first_dbg_gnt", 32'(dbg_gnt), 0);
        cpu_req = 1'b0;
        wait_gnt(1'b1);
        repeat (2) step();

        // CPU write then read back.
        cpu_do(1'b1, 8'h10, 8'h5A);
        chk("wr_wren", 32'(ram_wren), 1);
        chk("wr_addr", 32'(ram_addr), 32'h10);
        step();
        chk("wr_wren_clr", 32'(ram_wren), 0);
        cpu_do(1'b0, 8'h10, 8'h00);
        step();
        step();
        chk("rd_rvalid",     32'(cpu_rvalid), 1);
        chk("rd_rdata",      32'(cpu_rdata),  32'h5A);
        chk("rd_dbg_rvalid", 32'(dbg_rvalid), 0);

        // Round-robin with both ports hammering reads.
        cpu_we = 1'b0; cpu_addr = 8'h01; cpu_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = 8'h02; dbg_req = 1'b1;
        cg = 0; dg = 0;
        repeat (12) begin
            step();
            cg += int'(cpu_gnt);
            dg += int'(dbg_gnt);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (3) step();
        chk("rr_cpu_cnt", 32'(cg), 2);
        chk("rr_dbg_cnt", 32'(dg), 2);
        chk("rr_cpu_rdata", 32'(cpu_rdata), 32'hA1);
        chk("rr_dbg_rdata", 32'(dbg_rdata), 32'hA2);

        // Debug request raised during a CPU read's WAIT.
        cpu_do(1'b0, 8'h01, 8'h00);
        step();
        dbg_we = 1'b0; dbg_addr = 8'h02; dbg_req = 1'b1;
        step();
        chk("ovl_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("ovl_dbg_gnt_early", 32'(dbg_gnt), 0);
        step();
        chk("ovl_dbg_gnt", 32'(dbg_gnt), 1);
        dbg_req = 1'b0;
        repeat (2) step();
        chk("ovl_dbg_rdata", 32'(dbg_rdata), 32'hA2);

        // One-cycle debug pulse while busy is ignored.
        cpu_do(1'b1, 8'h20, 8'h11);
        chk("wd_busy", 32'(busy), 1);
        dbg_we = 1'b1; dbg_addr = 8'h77; dbg_wdata = 8'hEE; dbg_req = 1'b1;
        step();
        dbg_req = 1'b0;
        dg = 0;
        repeat (3) begin
            step();
            dg += int'(dbg_gnt);
        end
        chk("wd_no_gnt", 32'(dg), 0);
        cpu_do(1'b0, 8'h77, 8'h00);
        repeat (2) step();
        chk("wd_no_write", 32'(cpu_rdata == 8'hEE && ref_mem[8'h77] != 8'hEE), 0);

        // Reset during a read's WAIT: read is lost, next write/read works.
        cpu_do(1'b0, 8'h30, 8'h00);
        step();
        apply_reset(2);
        repeat (2) begin
            step();
            chk("rst_no_rvalid", 32'(cpu_rvalid), 0);
        end
        cpu_do(1'b1, 8'hFF, 8'h33);
        step();
        cpu_do(1'b0, 8'hFF, 8'h00);
        repeat (2) step();
        chk("post_rst_rdata", 32'(cpu_rdata), 32'h33);

        // Reset inside a write's ACCESS drops ram_wren asynchronously; rewrite the location.
        cpu_do(1'b1, 8'h44, 8'h99);
        chk("acc_wren_pre", 32'(ram_wren), 1);
        apply_reset(1);
        cpu_do(1'b1, 8'h44, 8'h55);
        step();

        // Random traffic from both ports.
        for (int i = 0; i < 800; i++) begin
            if (!cpu_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    new_txn(cpu_we, cpu_addr, cpu_wdata);
                    cpu_req = 1'b1;
                end
            end else if (edge_n < free_edge && $urandom_range(0, 9) == 0) begin
                cpu_req = 1'b0;
            end
            if (!dbg_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    new_txn(dbg_we, dbg_addr, dbg_wdata);
                    dbg_req = 1'b1;
                end
            end else if (edge_n < free_edge && $urandom_range(0, 9) == 0) begin
                dbg_req = 1'b0;
            end
            step();
            if (cpu_gnt) begin
                if ($urandom_range(0, 1) == 0) new_txn(cpu_we, cpu_addr, cpu_wdata);
                else                           cpu_req = 1'b0;
            end
            if (dbg_gnt) begin
                if ($urandom_range(0, 1) == 0) new_txn(dbg_we, dbg_addr, dbg_wdata);
                else                           dbg_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (4) step();
        chk("end_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
